// File: rtl/convolution_calculator.sv
// 1-D convolution processing element: two circular scratchpads feeding
// a single MAC that slides the current filter across each complete row.
module convolution_calculator #(
    parameter int IFMAP_NUM_OF_REG  = 5,
    parameter int FILTER_NUM_OF_REG = 7,
    parameter int ADDR_WIDTH_IFMAP  = 3,
    parameter int ADDR_WIDTH_FILTER = 4,
    parameter int ELEMENT_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ELEMENT_WIDTH+1:0]      IFMAP,
    input  logic                          write_en_IFMAP,
    input  logic [ELEMENT_WIDTH-1:0]      FILTER,
    input  logic                          write_en_filter,
    input  logic [IFMAP_NUM_OF_REG-1:0]   stride,
    input  logic [ADDR_WIDTH_FILTER-1:0]  filter_size,
    output logic [ELEMENT_WIDTH-1:0]      output_psum,
    output logic                          psum_valid,
    output logic                          ifmap_full,
    output logic                          filter_full
);

    localparam int N   = IFMAP_NUM_OF_REG;
    localparam int M   = FILTER_NUM_OF_REG;
    localparam int IA  = ADDR_WIDTH_IFMAP;
    localparam int FA  = ADDR_WIDTH_FILTER;
    localparam int EW  = ELEMENT_WIDTH;
    localparam int CW  = IA + 1;
    localparam int FCW = FA + 1;
    localparam int JW  = IFMAP_NUM_OF_REG + 1;
    localparam int AW  = 2 * EW + FA;

    typedef enum logic [1:0] {IDLE, WAIT, CALC} state_t;

    function automatic logic [IA-1:0] iwrap(input int v);
        return IA'(v % N);
    endfunction

    function automatic logic [FA-1:0] fwrap(input int v);
        return FA'(v % M);
    endfunction

    state_t            state_q, state_d;
    logic [EW-1:0]     imem_q [N];
    logic [EW-1:0]     imem_d [N];
    logic              endf_q [N];
    logic              endf_d [N];
    logic [IA-1:0]     iwr_q, iwr_d, ird_q, ird_d;
    logic [IA-1:0]     pstart_q, pstart_d;
    logic [CW-1:0]     icnt_q, icnt_d, icmpl_q, icmpl_d;
    logic [CW-1:0]     plen_q, plen_d;
    logic              in_row_q, in_row_d;
    logic [EW-1:0]     fmem_q [M];
    logic [EW-1:0]     fmem_d [M];
    logic [FA-1:0]     fwr_q, fwr_d, frd_q, frd_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [FA-1:0]     k_q, k_d, ksz_q, ksz_d;
    logic [JW-1:0]     j_q, j_d;
    logic [IFMAP_NUM_OF_REG-1:0] str_q, str_d;
    logic [CW-1:0]     len_q, len_d;
    logic              pend_q, pend_d;
    logic [EW-1:0]     out_q, out_d;
    logic              valid_q, valid_d;
    logic [CW-1:0]     row_len;
    logic [IA-1:0]     iidx, wpos;
    logic [FA-1:0]     fidx;
    logic              irel, frel;

    assign output_psum = out_q;
    assign psum_valid  = valid_q;
    assign ifmap_full  = (icnt_q == CW'(N));
    assign filter_full = (fcnt_q == FCW'(M));
    assign iidx = iwrap(int'(ird_q) + int'(j_q) + int'(k_q));
    assign fidx = fwrap(int'(frd_q) + int'(k_q));

    // Length of the oldest complete row: first end flag from the read base.
    always_comb begin
        row_len = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i < int'(icmpl_q) && endf_q[iwrap(int'(ird_q) + i)])
                row_len = CW'(i + 1);
        end
    end

    // Next-state: sequencing, MAC, row bookkeeping and scratchpad writes.
    always_comb begin
        state_d  = state_q;
        imem_d   = imem_q;
        endf_d   = endf_q;
        iwr_d    = iwr_q;
        ird_d    = ird_q;
        pstart_d = pstart_q;
        icnt_d   = icnt_q;
        icmpl_d  = icmpl_q;
        plen_d   = plen_q;
        in_row_d = in_row_q;
        fmem_d   = fmem_q;
        fwr_d    = fwr_q;
        frd_d    = frd_q;
        fcnt_d   = fcnt_q;
        acc_d    = acc_q;
        k_d      = k_q;
        ksz_d    = ksz_q;
        j_d      = j_q;
        str_d    = str_q;
        len_d    = len_q;
        pend_d   = pend_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        irel     = 1'b0;
        frel     = 1'b0;
        wpos     = iwr_q;
        if (start) begin
            state_d  = WAIT;
            iwr_d    = '0;
            ird_d    = '0;
            pstart_d = '0;
            icnt_d   = '0;
            icmpl_d  = '0;
            plen_d   = '0;
            in_row_d = 1'b0;
            fwr_d    = '0;
            frd_d    = '0;
            fcnt_d   = '0;
            acc_d    = '0;
            k_d      = '0;
            j_d      = '0;
            pend_d   = 1'b0;
        end else if (state_q != IDLE) begin
            if (state_q == WAIT && icmpl_q != '0) begin
                if (filter_size == '0) begin
                    irel = 1'b1;
                end else if (int'(fcnt_q) >= int'(filter_size)) begin
                    if (int'(filter_size) > int'(row_len)) begin
                        irel = 1'b1;
                    end else begin
                        state_d = CALC;
                        ksz_d   = filter_size;
                        str_d   = (stride == '0) ? IFMAP_NUM_OF_REG'(1) : stride;
                        len_d   = row_len;
                        j_d     = '0;
                        k_d     = '0;
                        pend_d  = 1'b0;
                    end
                end
            end
            if (state_q == CALC) begin
                if (pend_q) begin
                    out_d   = acc_q[EW-1:0];
                    valid_d = 1'b1;
                end
                if (int'(j_q) + int'(ksz_q) <= int'(len_q)) begin
                    acc_d = ((k_q == '0) ? '0 : acc_q)
                          + AW'(imem_q[iidx]) * AW'(fmem_q[fidx]);
                    if (k_q == ksz_q - FA'(1)) begin
                        k_d    = '0;
                        j_d    = j_q + JW'(str_q);
                        pend_d = 1'b1;
                    end else begin
                        k_d    = k_q + FA'(1);
                        pend_d = 1'b0;
                    end
                end else begin
                    irel    = 1'b1;
                    frel    = 1'b1;
                    pend_d  = 1'b0;
                    state_d = WAIT;
                end
            end
            if (irel) begin
                ird_d   = iwrap(int'(ird_q) + int'(row_len));
                icnt_d  = icnt_d - row_len;
                icmpl_d = icmpl_d - row_len;
            end
            if (frel) begin
                frd_d  = fwrap(int'(frd_q) + int'(ksz_q));
                fcnt_d = fcnt_d - FCW'(ksz_q);
            end
            if (write_en_IFMAP && !ifmap_full) begin
                if (IFMAP[EW+1]) begin
                    if (in_row_q) begin
                        wpos   = pstart_q;
                        icnt_d = icnt_d - plen_q;
                    end
                    imem_d[wpos] = IFMAP[EW-1:0];
                    endf_d[wpos] = IFMAP[EW];
                    iwr_d        = iwrap(int'(wpos) + 1);
                    icnt_d       = icnt_d + CW'(1);
                    pstart_d     = wpos;
                    if (IFMAP[EW]) begin
                        icmpl_d  = icmpl_d + CW'(1);
                        in_row_d = 1'b0;
                        plen_d   = '0;
                    end else begin
                        in_row_d = 1'b1;
                        plen_d   = CW'(1);
                    end
                end else if (in_row_q) begin
                    imem_d[iwr_q] = IFMAP[EW-1:0];
                    endf_d[iwr_q] = IFMAP[EW];
                    iwr_d         = iwrap(int'(iwr_q) + 1);
                    icnt_d        = icnt_d + CW'(1);
                    if (IFMAP[EW]) begin
                        icmpl_d  = icmpl_d + plen_q + CW'(1);
                        in_row_d = 1'b0;
                        plen_d   = '0;
                    end else begin
                        plen_d = plen_q + CW'(1);
                    end
                end
            end
            if (write_en_filter && !filter_full) begin
                fmem_d[fwr_q] = FILTER;
                fwr_d         = fwrap(int'(fwr_q) + 1);
                fcnt_d        = fcnt_d + FCW'(1);
            end
        end
    end

    // State register; asynchronous reset returns everything to idle zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < N; i++) begin
                imem_q[i] <= '0;
                endf_q[i] <= 1'b0;
            end
            for (int i = 0; i < M; i++) fmem_q[i] <= '0;
            iwr_q    <= '0;
            ird_q    <= '0;
            pstart_q <= '0;
            icnt_q   <= '0;
            icmpl_q  <= '0;
            plen_q   <= '0;
            in_row_q <= 1'b0;
            fwr_q    <= '0;
            frd_q    <= '0;
            fcnt_q   <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            ksz_q    <= '0;
            j_q      <= '0;
            str_q    <= '0;
            len_q    <= '0;
            pend_q   <= 1'b0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            imem_q   <= imem_d;
            endf_q   <= endf_d;
            fmem_q   <= fmem_d;
            iwr_q    <= iwr_d;
            ird_q    <= ird_d;
            pstart_q <= pstart_d;
            icnt_q   <= icnt_d;
            icmpl_q  <= icmpl_d;
            plen_q   <= plen_d;
            in_row_q <= in_row_d;
            fwr_q    <= fwr_d;
            frd_q    <= frd_d;
            fcnt_q   <= fcnt_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            ksz_q    <= ksz_d;
            j_q      <= j_d;
            str_q    <= str_d;
            len_q    <= len_d;
            pend_q   <= pend_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_convolution_calculator.sv
// Bench for convolution_calculator: directed scenarios plus randomized
// rows checked against a plain-arithmetic sliding-window model.
module tb_convolution_calculator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  IFMAP = '0;
    logic        write_en_IFMAP = 1'b0;
    logic [7:0]  FILTER = '0;
    logic        write_en_filter = 1'b0;
    logic [4:0]  stride = '0;
    logic [3:0]  filter_size = '0;
    logic [7:0]  output_psum;
    logic        psum_valid;
    logic        ifmap_full;
    logic        filter_full;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] mrow[$];
    logic [7:0] mfilt[$];
    logic [7:0] exp_q[$];

    convolution_calculator dut (
        .clk(clk), .rst(rst), .start(start),
        .IFMAP(IFMAP), .write_en_IFMAP(write_en_IFMAP),
        .FILTER(FILTER), .write_en_filter(write_en_filter),
        .stride(stride), .filter_size(filter_size),
        .output_psum(output_psum), .psum_valid(psum_valid),
        .ifmap_full(ifmap_full), .filter_full(filter_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (psum_valid) begin
            got_q.push_back(output_psum);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic wr_if(input logic s, input logic e, input logic [7:0] d);
        IFMAP = {s, e, d};
        write_en_IFMAP = 1'b1;
        tick();
        write_en_IFMAP = 1'b0;
    endtask

    task automatic wr_f(input logic [7:0] d);
        FILTER = d;
        write_en_filter = 1'b1;
        tick();
        write_en_filter = 1'b0;
    endtask

    task automatic wr_row();
        for (int i = 0; i < mrow.size(); i++)
            wr_if(i == 0, i == mrow.size() - 1, mrow[i]);
    endtask

    task automatic collect(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        repeat (4) tick();
    endtask

    // Every window j = 0, S, 2S.. with j+K <= L, truncated to 8 bits.
    function automatic void model(input int k, input int s, input int fo);
        int sum;
        if (s == 0) s = 1;
        for (int j = 0; k > 0 && j + k <= mrow.size(); j += s) begin
            sum = 0;
            for (int t = 0; t < k; t++) sum += mrow[j + t] * mfilt[fo + t];
            exp_q.push_back(8'(sum));
        end
    endfunction

    task automatic cmp_psums(input string name);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s count got=%0d exp=%0d", name,
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s psum[%0d] got=%h exp=%h", name, i,
                         got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (output_psum !== 8'h00 || psum_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%h/%b exp=00/0", output_psum, psum_valid);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) wr_if(i == 0, 1'b0, 8'(i + 1));
        for (int i = 0; i < 7; i++) wr_f(8'h01);
        checks++;
        if (ifmap_full !== 1'b0 || filter_full !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore got=%b%b exp=00", ifmap_full, filter_full);
        end
    endtask

    task automatic test_basic_stride1();
        int c_end;
        do_start();
        filter_size = 4'd3;
        stride = 5'd1;
        for (int i = 0; i < 3; i++) wr_f(8'h01);
        mrow = '{8'd1, 8'd2, 8'd3, 8'd4};
        wr_row();
        c_end = cyc;
        collect(2, 40);
        exp_q = '{8'd6, 8'd9};
        cmp_psums("basic");
        checks++;
        if (got_cyc.size() < 1 || got_cyc[0] !== c_end + 5) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d",
                     got_cyc.size() ? got_cyc[0] - c_end : -1, 5);
        end
        repeat (3) tick();
        checks++;
        if (output_psum !== 8'd9 || psum_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold got=%h/%b exp=09/0", output_psum, psum_valid);
        end
    endtask

    task automatic test_stride2();
        do_start();
        filter_size = 4'd3;
        stride = 5'd2;
        for (int i = 0; i < 7; i++) wr_f(8'h01);
        checks++;
        if (filter_full !== 1'b1) begin
            failures++;
            $display("FAIL ffull_set got=%b exp=1", filter_full);
        end
        mrow = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        wr_row();
        collect(2, 40);
        exp_q = '{8'd6, 8'd12};
        cmp_psums("stride2");
        checks++;
        if (filter_full !== 1'b0 || ifmap_full !== 1'b0) begin
            failures++;
            $display("FAIL release got=%b%b exp=00", filter_full, ifmap_full);
        end
        wr_f(8'h01);
        wr_f(8'h01);
        checks++;
        if (filter_full !== 1'b0) begin
            failures++;
            $display("FAIL ffree2 got=%b exp=0", filter_full);
        end
        wr_f(8'h01);
        checks++;
        if (filter_full !== 1'b1) begin
            failures++;
            $display("FAIL ffree3 got=%b exp=1", filter_full);
        end
    endtask

    task automatic test_truncation();
        do_start();
        filter_size = 4'd2;
        stride = 5'd1;
        wr_f(8'hFF);
        wr_f(8'h01);
        mrow = '{8'hFF, 8'hFF};
        wr_row();
        collect(1, 30);
        exp_q = '{8'h00};
        cmp_psums("trunc");
    endtask

    task automatic test_two_filters();
        do_start();
        filter_size = 4'd3;
        stride = 5'd1;
        mfilt = '{8'h80, 8'h94, 8'hFF, 8'h55, 8'h95, 8'h6A};
        for (int i = 0; i < 6; i++) wr_f(mfilt[i]);
        mrow = '{8'hFF, 8'hFF, 8'hFC, 8'hFC, 8'hF8};
        wr_row();
        exp_q.delete();
        model(3, 1, 0);
        collect(exp_q.size(), 60);
        cmp_psums("filter1");
        got_q.delete();
        exp_q.delete();
        mrow = '{8'hFF, 8'hFC, 8'hF8};
        wr_row();
        model(3, 1, 3);
        collect(exp_q.size(), 60);
        cmp_psums("filter2");
    endtask

    task automatic test_back_to_back();
        do_start();
        filter_size = 4'd2;
        stride = 5'd1;
        mfilt.delete();
        for (int i = 0; i < 4; i++) begin
            mfilt.push_back(8'($urandom));
            wr_f(mfilt[i]);
        end
        mrow = '{8'($urandom), 8'($urandom)};
        exp_q.delete();
        model(2, 1, 0);
        wr_row();
        mrow = '{8'($urandom), 8'($urandom), 8'($urandom)};
        model(2, 1, 2);
        wr_row();
        collect(exp_q.size(), 60);
        cmp_psums("b2b");
    endtask

    task automatic test_overflow();
        do_start();
        filter_size = 4'd3;
        for (int i = 0; i < 5; i++) wr_if(i == 0, 1'b0, 8'(i));
        checks++;
        if (ifmap_full !== 1'b1) begin
            failures++;
            $display("FAIL ifull_5 got=%b exp=1", ifmap_full);
        end
        wr_if(1'b0, 1'b0, 8'h55);
        checks++;
        if (ifmap_full !== 1'b1) begin
            failures++;
            $display("FAIL ifull_6 got=%b exp=1", ifmap_full);
        end
        do_start();
        checks++;
        if (ifmap_full !== 1'b0) begin
            failures++;
            $display("FAIL start_clear got=%b exp=0", ifmap_full);
        end
    endtask

    task automatic test_kzero();
        do_start();
        filter_size = 4'd0;
        mrow = '{8'd3, 8'd4, 8'd5};
        wr_row();
        mrow = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        wr_row();
        repeat (3) tick();
        checks++;
        if (ifmap_full !== 1'b0 || got_q.size() !== 0) begin
            failures++;
            $display("FAIL kzero got=%b/%0d exp=0/0", ifmap_full, got_q.size());
        end
    endtask

    task automatic test_random();
        int l, k, s;
        for (int it = 0; it < 12; it++) begin
            do_start();
            l = $urandom_range(1, 5);
            k = $urandom_range(1, 5);
            s = $urandom_range(0, 3);
            filter_size = 4'(k);
            stride = 5'(s);
            mfilt.delete();
            mrow.delete();
            for (int i = 0; i < k; i++) begin
                mfilt.push_back(8'($urandom));
                wr_f(mfilt[i]);
            end
            for (int i = 0; i < l; i++) mrow.push_back(8'($urandom));
            exp_q.delete();
            model(k, s, 0);
            wr_row();
            collect(exp_q.size(), 80);
            cmp_psums($sformatf("rand%0d_L%0dK%0dS%0d", it, l, k, s));
            checks++;
            if (ifmap_full !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_release got=%b exp=0", it, ifmap_full);
            end
        end
    endtask

    task automatic test_rst_mid_calc();
        int t = 0;
        int n;
        do_start();
        filter_size = 4'd3;
        stride = 5'd1;
        for (int i = 0; i < 3; i++) wr_f(8'h01);
        mrow = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        wr_row();
        while (got_q.size() < 1 && t < 30) begin
            tick();
            t++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (output_psum !== 8'h00 || psum_valid !== 1'b0 || got_q.size() < 1) begin
            failures++;
            $display("FAIL rst_abort got=%h/%b n=%0d exp=00/0 n>=1",
                     output_psum, psum_valid, got_q.size());
        end
        tick();
        rst = 1'b0;
        n = got_q.size();
        for (int i = 0; i < 3; i++) wr_f(8'h01);
        wr_row();
        repeat (20) tick();
        checks++;
        if (got_q.size() !== n || ifmap_full !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got=%0d/%b exp=%0d/0",
                     got_q.size(), ifmap_full, n);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stride1();
        test_stride2();
        test_truncation();
        test_two_filters();
        test_back_to_back();
        test_overflow();
        test_kzero();
        test_random();
        test_rst_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
